// File: rtl/conv_17_sdiv_seq_pkg.sv
// Shared definitions for the conv_17 sequential signed divider:
// FSM state encoding, default widths and quotient saturation limits.
package conv_17_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  localparam int DEF_DIVIDEND_W = 24;
  localparam int DEF_DIVISOR_W  = 8;
  localparam int DEF_QUOTIENT_W = 16;

  // Magnitude of the saturation bound for a qw-bit signed quotient:
  // 2^(qw-1)-1 on the positive side, 2^(qw-1) on the negative side.
  function automatic longint unsigned quot_limit_mag(input int qw, input bit neg);
    return neg ? (64'd1 << (qw - 1)) : ((64'd1 << (qw - 1)) - 64'd1);
  endfunction

  localparam longint unsigned QUOT_POS_MAG = quot_limit_mag(DEF_QUOTIENT_W, 1'b0);
  localparam longint unsigned QUOT_NEG_MAG = quot_limit_mag(DEF_QUOTIENT_W, 1'b1);

endpackage

// File: rtl/conv_17_sdiv_seq_if.sv
// Operand/result handshake bundle for the conv_17 sequential divider.
interface conv_17_sdiv_seq_if
  import conv_17_div_pkg::*;
#(
  parameter int DIVIDEND_W = DEF_DIVIDEND_W,
  parameter int DIVISOR_W  = DEF_DIVISOR_W,
  parameter int QUOTIENT_W = DEF_QUOTIENT_W
);

  logic                         din_valid;
  logic                         din_ready;
  logic signed [DIVIDEND_W-1:0] din0;
  logic signed [DIVISOR_W-1:0]  din1;
  logic                         dout_valid;
  logic                         dout_ready;
  logic signed [QUOTIENT_W-1:0] quot;
  logic signed [DIVISOR_W-1:0]  rem;
  logic                         div_by_zero;
  logic                         overflow;

  modport master (
    output din_valid, din0, din1, dout_ready,
    input  din_ready, dout_valid, quot, rem, div_by_zero, overflow
  );

  modport slave (
    input  din_valid, din0, din1, dout_ready,
    output din_ready, dout_valid, quot, rem, div_by_zero, overflow
  );

endinterface

// File: rtl/conv_17_sdiv_seq_core.sv
// Unsigned restoring divider step: one quotient bit per enabled cycle.
// Holds the dividend shift register, partial remainder, quotient
// magnitude and the bit counter.
module conv_17_sdiv_seq_core #(
  parameter int DIVIDEND_W = 24,
  parameter int DIVISOR_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  step,
  input  logic [DIVIDEND_W-1:0] dvd_mag,
  input  logic [DIVISOR_W-1:0]  dvs_mag,
  output logic [DIVIDEND_W-1:0] quot_mag,
  output logic [DIVISOR_W-1:0]  rem_mag,
  output logic                  last
);

  localparam int CNT_W = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;

  logic [DIVIDEND_W-1:0] dvd_sh;
  logic [DIVIDEND_W-1:0] qreg;
  logic [DIVISOR_W-1:0]  dvs;
  logic [DIVISOR_W:0]    prem;
  logic [CNT_W-1:0]      cnt;
  logic [DIVISOR_W+1:0]  shifted;
  logic [DIVISOR_W+1:0]  trial;

  // Bring down the next dividend bit and trial-subtract the divisor;
  // the extra top bit of trial acts as the borrow.
  always_comb begin
    shifted = {prem, dvd_sh[DIVIDEND_W-1]};
    trial   = shifted - {2'b00, dvs};
  end

  // Load operands, then iterate one restoring step per enabled cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvd_sh <= '0;
      qreg   <= '0;
      dvs    <= '0;
      prem   <= '0;
      cnt    <= '0;
    end else if (load) begin
      dvd_sh <= dvd_mag;
      qreg   <= '0;
      dvs    <= dvs_mag;
      prem   <= '0;
      cnt    <= CNT_W'(DIVIDEND_W - 1);
    end else if (step) begin
      dvd_sh <= {dvd_sh[DIVIDEND_W-2:0], 1'b0};
      if (!trial[DIVISOR_W+1]) begin
        prem <= trial[DIVISOR_W:0];
        qreg <= {qreg[DIVIDEND_W-2:0], 1'b1};
      end else begin
        prem <= shifted[DIVISOR_W:0];
        qreg <= {qreg[DIVIDEND_W-2:0], 1'b0};
      end
      if (cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  assign quot_mag = qreg;
  assign rem_mag  = prem[DIVISOR_W-1:0];
  assign last     = (cnt == '0);

endmodule

// File: rtl/conv_17_sdiv_seq.sv
// Sequential signed divider for the conv_17 datapath: rescales a signed
// accumulator by a signed 8-bit divisor. Holds the control FSM, sign
// handling, quotient saturation and the valid/ready handshakes.
module conv_17_sdiv_seq
  import conv_17_div_pkg::*;
#(
  parameter int DIVIDEND_W = DEF_DIVIDEND_W,
  parameter int DIVISOR_W  = DEF_DIVISOR_W,
  parameter int QUOTIENT_W = DEF_QUOTIENT_W
) (
  input logic               ap_clk,
  input logic               ap_rst,
  conv_17_sdiv_seq_if.slave bus
);

  localparam logic [DIVIDEND_W-1:0] POS_LIM =
    DIVIDEND_W'(quot_limit_mag(QUOTIENT_W, 1'b0));
  localparam logic [DIVIDEND_W-1:0] NEG_LIM =
    DIVIDEND_W'(quot_limit_mag(QUOTIENT_W, 1'b1));
  localparam logic signed [QUOTIENT_W-1:0] Q_MAX =
    QUOTIENT_W'(quot_limit_mag(QUOTIENT_W, 1'b0));
  localparam logic signed [QUOTIENT_W-1:0] Q_MIN =
    QUOTIENT_W'(quot_limit_mag(QUOTIENT_W, 1'b1));

  div_state_t state;
  div_state_t next;

  logic                         load;
  logic                         step;
  logic                         last;
  logic                         zero_div;
  logic                         sign_dvd;
  logic                         sign_dvs;
  logic [DIVIDEND_W-1:0]        dvd_mag;
  logic [DIVISOR_W-1:0]         dvs_mag;
  logic [DIVIDEND_W-1:0]        quot_mag;
  logic [DIVISOR_W-1:0]         rem_mag;
  logic signed [DIVISOR_W-1:0]  rem_s;
  logic signed [QUOTIENT_W-1:0] fix_quot;
  logic signed [DIVISOR_W-1:0]  fix_rem;
  logic                         fix_clip;
  logic signed [QUOTIENT_W-1:0] quot_r;
  logic signed [DIVISOR_W-1:0]  rem_r;
  logic                         dbz_r;
  logic                         ovf_r;
  logic                         din_ready_r;
  logic                         dout_valid_r;

  // Apply the sign to the unsigned quotient magnitude and clip it to the
  // signed QUOTIENT_W range; clipped reports whether the bound was hit.
  function automatic logic signed [QUOTIENT_W-1:0] sat_quot(
    input  logic [DIVIDEND_W-1:0] mag,
    input  logic                  neg,
    output logic                  clipped
  );
    logic signed [QUOTIENT_W-1:0] q;
    clipped = 1'b0;
    if (!neg) begin
      if (mag > POS_LIM) begin
        q       = Q_MAX;
        clipped = 1'b1;
      end else begin
        q = QUOTIENT_W'(mag);
      end
    end else begin
      if (mag > NEG_LIM) begin
        q       = Q_MIN;
        clipped = 1'b1;
      end else begin
        q = -(QUOTIENT_W'(mag));
      end
    end
    return q;
  endfunction

  // Operand magnitudes; the most negative value maps onto its unsigned
  // magnitude because the result width equals the operand width.
  always_comb begin
    dvd_mag  = bus.din0[DIVIDEND_W-1] ? -bus.din0 : bus.din0;
    dvs_mag  = bus.din1[DIVISOR_W-1]  ? -bus.din1 : bus.din1;
    zero_div = (bus.din1 == '0);
  end

  conv_17_sdiv_seq_core #(
    .DIVIDEND_W (DIVIDEND_W),
    .DIVISOR_W  (DIVISOR_W)
  ) u_core (
    .clk      (ap_clk),
    .rst      (ap_rst),
    .load     (load),
    .step     (step),
    .dvd_mag  (dvd_mag),
    .dvs_mag  (dvs_mag),
    .quot_mag (quot_mag),
    .rem_mag  (rem_mag),
    .last     (last)
  );

  // FSM state register.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state <= IDLE;
    end else begin
      state <= next;
    end
  end

  // Next-state and core control; leaving DONE needs a completed output handshake.
  always_comb begin
    next = state;
    load = 1'b0;
    step = 1'b0;
    case (state)
      IDLE: begin
        if (bus.din_valid) begin
          load = 1'b1;
          next = zero_div ? DONE : CALC;
        end
      end
      CALC: begin
        step = 1'b1;
        if (last) begin
          next = FIX;
        end
      end
      FIX: begin
        next = DONE;
      end
      DONE: begin
        if (dout_valid_r && bus.dout_ready) begin
          next = IDLE;
        end
      end
      default: begin
        next = IDLE;
      end
    endcase
  end

  // Operand signs captured at acceptance, used when the result is fixed up.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      sign_dvd <= 1'b0;
      sign_dvs <= 1'b0;
    end else if (load) begin
      sign_dvd <= bus.din0[DIVIDEND_W-1];
      sign_dvs <= bus.din1[DIVISOR_W-1];
    end
  end

  // Signed result: quotient truncates toward zero, remainder follows the dividend.
  always_comb begin
    rem_s    = rem_mag;
    fix_clip = 1'b0;
    fix_quot = sat_quot(quot_mag, sign_dvd ^ sign_dvs, fix_clip);
    fix_rem  = sign_dvd ? -rem_s : rem_s;
  end

  // Result registers: written by the divide-by-zero shortcut or by FIX, then held.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      quot_r <= '0;
      rem_r  <= '0;
      dbz_r  <= 1'b0;
      ovf_r  <= 1'b0;
    end else if (load && zero_div) begin
      quot_r <= bus.din0[DIVIDEND_W-1] ? Q_MIN : Q_MAX;
      rem_r  <= '0;
      dbz_r  <= 1'b1;
      ovf_r  <= 1'b0;
    end else if (state == FIX) begin
      quot_r <= fix_quot;
      rem_r  <= fix_rem;
      dbz_r  <= 1'b0;
      ovf_r  <= fix_clip;
    end
  end

  // Handshake flags: results settle for one cycle in DONE before dout_valid rises.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      din_ready_r  <= 1'b1;
      dout_valid_r <= 1'b0;
    end else begin
      din_ready_r  <= (next == IDLE);
      dout_valid_r <= (state == DONE) && !(dout_valid_r && bus.dout_ready);
    end
  end

  assign bus.din_ready   = din_ready_r;
  assign bus.dout_valid  = dout_valid_r;
  assign bus.quot        = quot_r;
  assign bus.rem         = rem_r;
  assign bus.div_by_zero = dbz_r;
  assign bus.overflow    = ovf_r;

endmodule

// File: tb/tb_conv_17_sdiv_seq.sv
// Directed bench for conv_17_sdiv_seq: signed division cases, divide by
// zero, saturation bounds, output backpressure and asynchronous abort.
module tb_conv_17_sdiv_seq;

  logic ap_clk = 1'b0;
  logic ap_rst;
  int   checks   = 0;
  int   failures = 0;
  int   spurious;

  always #5 ap_clk = ~ap_clk;

  conv_17_sdiv_seq_if #(
    .DIVIDEND_W (24),
    .DIVISOR_W  (8),
    .QUOTIENT_W (16)
  ) bus ();

  conv_17_sdiv_seq #(
    .DIVIDEND_W (24),
    .DIVISOR_W  (8),
    .QUOTIENT_W (16)
  ) dut (
    .ap_clk (ap_clk),
    .ap_rst (ap_rst),
    .bus    (bus)
  );

  task automatic chk(input string tag, input logic signed [63:0] obs_v,
                     input logic signed [63:0] exp_v);
    checks++;
    assert (obs_v === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs_v, exp_v);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_din_ready"},   64'(bus.din_ready),   64'(1));
    chk({tag, "_dout_valid"},  64'(bus.dout_valid),  64'(0));
    chk({tag, "_quot"},        64'(bus.quot),        64'(0));
    chk({tag, "_rem"},         64'(bus.rem),         64'(0));
    chk({tag, "_div_by_zero"}, 64'(bus.div_by_zero), 64'(0));
    chk({tag, "_overflow"},    64'(bus.overflow),    64'(0));
  endtask

  // Present one operation, measure latency from the input handshake edge
  // to dout_valid, check the result, then (unless hold) the output handshake.
  task automatic run_op(input string tag, input int a, input int b,
                        input int exp_q, input int exp_r, input int exp_dbz,
                        input int exp_ovf, input int exp_lat, input bit hold);
    int lat;
    @(negedge ap_clk);
    chk({tag, "_in_ready"}, 64'(bus.din_ready), 64'(1));
    bus.din_valid = 1'b1;
    bus.din0      = 24'(a);
    bus.din1      = 8'(b);
    @(posedge ap_clk);
    #1;
    bus.din_valid = 1'b0;
    lat = 0;
    while (bus.dout_valid !== 1'b1 && lat < 60) begin
      @(posedge ap_clk);
      #1;
      lat++;
    end
    chk({tag, "_latency"},     64'(lat),             64'(exp_lat));
    chk({tag, "_quot"},        64'(bus.quot),        64'(exp_q));
    chk({tag, "_rem"},         64'(bus.rem),         64'(exp_r));
    chk({tag, "_div_by_zero"}, 64'(bus.div_by_zero), 64'(exp_dbz));
    chk({tag, "_overflow"},    64'(bus.overflow),    64'(exp_ovf));
    if (!hold) begin
      @(posedge ap_clk);
      #1;
      chk({tag, "_post_valid"}, 64'(bus.dout_valid), 64'(0));
      chk({tag, "_post_ready"}, 64'(bus.din_ready),  64'(1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.din_valid  = 1'b0;
    bus.din0       = '0;
    bus.din1       = '0;
    bus.dout_ready = 1'b1;
    ap_rst         = 1'b0;
    #2;
    ap_rst = 1'b1;
    #1;
    chk_reset_state("reset");
    repeat (2) @(posedge ap_clk);
    @(negedge ap_clk);
    ap_rst = 1'b0;

    // Basic signed division, truncation toward zero.
    run_op("p1000_d7",   1000,    7,  142,  6, 0, 0, 26, 1'b0);
    run_op("n1000_d7",  -1000,    7, -142, -6, 0, 0, 26, 1'b0);
    run_op("p1000_dn7",  1000,   -7, -142,  6, 0, 0, 26, 1'b0);
    run_op("n128_dn128", -128, -128,    1,  0, 0, 0, 26, 1'b0);
    run_op("p7_dn128",      7, -128,    0,  7, 0, 0, 26, 1'b0);

    // Divide by zero shortcut.
    run_op("p1000_d0", 1000, 0,  32767, 0, 1, 0, 1, 1'b0);
    run_op("n5_d0",      -5, 0, -32768, 0, 1, 0, 1, 1'b0);

    // Saturation bounds.
    run_op("min_dn1", -8388608, -1,  32767, 0, 0, 1, 26, 1'b0);
    run_op("max_d1",   8388607,  1,  32767, 0, 0, 1, 26, 1'b0);
    run_op("q_max_d1",   32767,  1,  32767, 0, 0, 0, 26, 1'b0);
    run_op("q_min_d1",  -32768,  1, -32768, 0, 0, 0, 26, 1'b0);
    run_op("q_minm1",   -32769,  1, -32768, 0, 0, 1, 26, 1'b0);

    // Backpressure: result held, new operands ignored while DONE.
    bus.dout_ready = 1'b0;
    run_op("bp", 50, 7, 7, 1, 0, 0, 26, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge ap_clk);
      bus.din_valid = ~i[0];
      bus.din0      = 24'(999);
      bus.din1      = 8'(3);
      @(posedge ap_clk);
      #1;
      chk("bp_hold_valid", 64'(bus.dout_valid), 64'(1));
      chk("bp_hold_ready", 64'(bus.din_ready),  64'(0));
      chk("bp_hold_quot",  64'(bus.quot),       64'(7));
      chk("bp_hold_rem",   64'(bus.rem),        64'(1));
    end
    @(negedge ap_clk);
    bus.din_valid  = 1'b0;
    bus.dout_ready = 1'b1;
    @(posedge ap_clk);
    #1;
    chk("bp_release_valid", 64'(bus.dout_valid), 64'(0));
    chk("bp_release_ready", 64'(bus.din_ready),  64'(1));
    spurious = 0;
    repeat (30) begin
      @(posedge ap_clk);
      #1;
      if (bus.dout_valid !== 1'b0) spurious++;
    end
    chk("bp_no_second_op", 64'(spurious), 64'(0));

    // Asynchronous reset in the middle of CALC aborts the operation.
    @(negedge ap_clk);
    bus.din_valid = 1'b1;
    bus.din0      = 24'(100000);
    bus.din1      = 8'(3);
    @(posedge ap_clk);
    #1;
    bus.din_valid = 1'b0;
    repeat (12) @(posedge ap_clk);
    #1;
    chk("calc_busy_ready", 64'(bus.din_ready), 64'(0));
    #2;
    ap_rst = 1'b1;
    #1;
    chk_reset_state("abort");
    @(negedge ap_clk);
    ap_rst = 1'b0;
    run_op("after_abort", 100, 10, 10, 0, 0, 0, 26, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
